// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one combinational memory between fetch and data ports.
// Define MEM_ARB_PERF_EN to add saturating grant/conflict counters.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ireq_val,
  output logic              ireq_rdy,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_val,
  output logic [31:0]       iresp_data,
  input  logic              dreq_val,
  output logic              dreq_rdy,
  input  logic              dreq_type,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [31:0]       dreq_wdata,
  output logic              dresp_val,
  output logic [31:0]       dresp_rdata,
  output logic              memreq_val,
  output logic              memreq_type,
  output logic [ADDR_W-1:0] memreq_addr,
  output logic [31:0]       memreq_wdata,
  input  logic [31:0]       memresp_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       icount,
  output logic [15:0]       dcount,
  output logic [15:0]       conflicts
`endif
);

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  gnt_e last_gnt;
  gnt_e last_gnt_nx;
  logic gnt_i;
  logic gnt_d;

  // Grants depend only on val and last_gnt, never on memory data.
  always_comb begin
    gnt_i       = 1'b0;
    gnt_d       = 1'b0;
    last_gnt_nx = last_gnt;
    if (rst_n) begin
      if (ireq_val && dreq_val) begin
        gnt_i = (last_gnt == GNT_D);
        gnt_d = (last_gnt == GNT_I);
      end else begin
        gnt_i = ireq_val;
        gnt_d = dreq_val;
      end
    end
    if (gnt_i) last_gnt_nx = GNT_I;
    if (gnt_d) last_gnt_nx = GNT_D;
  end

  assign ireq_rdy = gnt_i;
  assign dreq_rdy = gnt_d;

  always_comb begin
    memreq_val   = 1'b0;
    memreq_type  = 1'b0;
    memreq_addr  = '0;
    memreq_wdata = '0;
    unique case (1'b1)
      gnt_i: begin
        memreq_val  = 1'b1;
        memreq_addr = ireq_addr;
      end
      gnt_d: begin
        memreq_val   = 1'b1;
        memreq_type  = dreq_type;
        memreq_addr  = dreq_addr;
        memreq_wdata = dreq_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt    <= GNT_D;
      iresp_val   <= 1'b0;
      dresp_val   <= 1'b0;
      iresp_data  <= '0;
      dresp_rdata <= '0;
    end else begin
      last_gnt  <= last_gnt_nx;
      iresp_val <= gnt_i;
      dresp_val <= gnt_d;
      if (gnt_i) iresp_data <= memresp_rdata;
      if (gnt_d) dresp_rdata <= dreq_type ? 32'h0 : memresp_rdata;
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icount    <= '0;
      dcount    <= '0;
      conflicts <= '0;
    end else begin
      if (gnt_i && icount != 16'hFFFF) icount <= icount + 16'd1;
      if (gnt_d && dcount != 16'hFFFF) dcount <= dcount + 16'd1;
      if (ireq_val && dreq_val && conflicts != 16'hFFFF)
        conflicts <= conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small combinational memory model.
// Build with MEM_ARB_PERF_EN to also exercise the counters.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst_n;
  logic              ireq_val;
  logic              ireq_rdy;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_val;
  logic [31:0]       iresp_data;
  logic              dreq_val;
  logic              dreq_rdy;
  logic              dreq_type;
  logic [ADDR_W-1:0] dreq_addr;
  logic [31:0]       dreq_wdata;
  logic              dresp_val;
  logic [31:0]       dresp_rdata;
  logic              memreq_val;
  logic              memreq_type;
  logic [ADDR_W-1:0] memreq_addr;
  logic [31:0]       memreq_wdata;
  logic [31:0]       memresp_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [15:0]       icount;
  logic [15:0]       dcount;
  logic [15:0]       conflicts;
`endif

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ireq_val     (ireq_val),
    .ireq_rdy     (ireq_rdy),
    .ireq_addr    (ireq_addr),
    .iresp_val    (iresp_val),
    .iresp_data   (iresp_data),
    .dreq_val     (dreq_val),
    .dreq_rdy     (dreq_rdy),
    .dreq_type    (dreq_type),
    .dreq_addr    (dreq_addr),
    .dreq_wdata   (dreq_wdata),
    .dresp_val    (dresp_val),
    .dresp_rdata  (dresp_rdata),
    .memreq_val   (memreq_val),
    .memreq_type  (memreq_type),
    .memreq_addr  (memreq_addr),
    .memreq_wdata (memreq_wdata),
    .memresp_rdata(memresp_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .icount       (icount),
    .dcount       (dcount),
    .conflicts    (conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              wr_vld;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  function automatic logic [31:0] base_word(input logic [ADDR_W-1:0] a);
    if (a == 32'h80) return 32'h24;
    return {16'hA5A5, a[15:0]};
  endfunction

  assign memresp_rdata = (wr_vld && wr_addr == memreq_addr) ?
                         wr_data : base_word(memreq_addr);

  always @(posedge clk) begin
    if (memreq_val && memreq_type) begin
      wr_vld  <= 1'b1;
      wr_addr <= memreq_addr;
      wr_data <= memreq_wdata;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    failures++;
    $error("FAIL timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    wr_vld     = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    rst_n      = 1'b0;
    ireq_val   = 1'b1;
    ireq_addr  = '0;
    dreq_val   = 1'b1;
    dreq_type  = 1'b0;
    dreq_addr  = 32'h80;
    dreq_wdata = '0;

    step();
    step();
    chk("rst_irdy", ireq_rdy, 1'b0);
    chk("rst_drdy", dreq_rdy, 1'b0);
    chk("rst_mval", memreq_val, 1'b0);
    chk("rst_ival", iresp_val, 1'b0);
    chk("rst_dval", dresp_val, 1'b0);
    chk("rst_idat", iresp_data, 32'h0);
    chk("rst_ddat", dresp_rdata, 32'h0);
    rst_n = 1'b1;

    #1;
    chk("a_irdy", ireq_rdy, 1'b1);
    chk("a_drdy", dreq_rdy, 1'b0);
    chk("a_mval", memreq_val, 1'b1);
    chk("a_maddr", memreq_addr, 32'h0);
    step();
    chk("a2_drdy", dreq_rdy, 1'b1);
    chk("a2_irdy", ireq_rdy, 1'b0);
    chk("a2_maddr", memreq_addr, 32'h80);
    chk("a2_ival", iresp_val, 1'b1);
    chk("a2_idat", iresp_data, 32'hA5A5_0000);
    step();
    ireq_val = 1'b0;
    dreq_val = 1'b0;
    chk("a3_dval", dresp_val, 1'b1);
    chk("a3_ddat", dresp_rdata, 32'h24);
    chk("a3_ival", iresp_val, 1'b0);

    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_mval", memreq_val, 1'b0);
      chk("idle_maddr", memreq_addr, 32'h0);
      chk("idle_mtype", memreq_type, 1'b0);
      chk("idle_irdy", ireq_rdy, 1'b0);
      chk("idle_drdy", dreq_rdy, 1'b0);
      chk("idle_ival", iresp_val, 1'b0);
      chk("idle_dval", dresp_val, 1'b0);
    end

    ireq_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ireq_addr = 32'(4 * k);
      #1;
      chk("f_irdy", ireq_rdy, 1'b1);
      chk("f_maddr", memreq_addr, 32'(4 * k));
      step();
      chk("f_ival", iresp_val, 1'b1);
      chk("f_idat", iresp_data, 32'hA5A5_0000 + 32'(4 * k));
    end
    ireq_val = 1'b0;
    step();
    chk("f_ival_off", iresp_val, 1'b0);
    chk("f_idat_hold", iresp_data, 32'hA5A5_000C);

    dreq_val   = 1'b1;
    dreq_type  = 1'b1;
    dreq_addr  = 32'h84;
    dreq_wdata = 32'hDEAD;
    #1;
    chk("w_drdy", dreq_rdy, 1'b1);
    chk("w_mtype", memreq_type, 1'b1);
    chk("w_mwdat", memreq_wdata, 32'hDEAD);
    step();
    dreq_type  = 1'b0;
    dreq_wdata = '0;
    chk("w_dval", dresp_val, 1'b1);
    chk("w_ddat", dresp_rdata, 32'h0);
    #1;
    chk("r_drdy", dreq_rdy, 1'b1);
    chk("r_mtype", memreq_type, 1'b0);
    step();
    dreq_val = 1'b0;
    chk("r_dval", dresp_val, 1'b1);
    chk("r_ddat", dresp_rdata, 32'hDEAD);

    step();
    dreq_val  = 1'b1;
    dreq_addr = 32'h80;
    step();
    dreq_val = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rr_dval", dresp_val, 1'b0);
    chk("rr_ddat", dresp_rdata, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("rr_dval2", dresp_val, 1'b0);

    ireq_val = 1'b1;
    step();
    ireq_val = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n    = 1'b1;
    ireq_val = 1'b1;
    dreq_val = 1'b1;
    #1;
    chk("t_irdy", ireq_rdy, 1'b1);
    chk("t_drdy", dreq_rdy, 1'b0);

`ifdef MEM_ARB_PERF_EN
    rst_n = 1'b0;
    step();
    chk("p_rst_cnt", conflicts, 16'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 70000; k++) @(posedge clk);
    #1;
    ireq_val = 1'b0;
    dreq_val = 1'b0;
    chk("p_conf", conflicts, 16'hFFFF);
    chk("p_icnt", icount, 16'h88B8);
    chk("p_dcnt", dcount, 16'h88B8);
`else
    step();
    ireq_val = 1'b0;
    dreq_val = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
